prt_riscv_cpu_wb: RTL and testbench

Writeback/scoreboard stage that drives the write port of the CPU register file.
- Merges ALU results and out-of-band load responses into one registered write per cycle, ALU first.
- Tracks register indices of outstanding loads in an in-order queue.
- Flags RAW/WAW hazards on the next instruction's source and destination registers so the issue stage can stall.

---
 rtl/prt_riscv_cpu_pkg.sv | 23 ++
 rtl/prt_riscv_cpu_wb_if.sv | 53 +++++
 rtl/prt_riscv_cpu_wb_ldq.sv | 107 ++++++++++
 rtl/prt_riscv_cpu_wb.sv | 99 +++++++++
 tb/tb_prt_riscv_cpu_wb.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prt_riscv_cpu_pkg.sv
// Shared types for the CPU writeback slice.
//   P_IDX_DEF  : default register-index width
//   reg_idx_t  : architectural register index
//   wb_port_t  : one register-file write {wr, idx, dat}
//   idx_nonzero: true when an index names a writable register (x0 is hardwired)
package prt_riscv_cpu_pkg;

  localparam int unsigned P_IDX_DEF = 4;
  localparam int unsigned XLEN      = 32;

  typedef logic [P_IDX_DEF-1:0] reg_idx_t;

  typedef struct packed {
    logic            wr;
    reg_idx_t        idx;
    logic [XLEN-1:0] dat;
  } wb_port_t;

  function automatic logic idx_nonzero(reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/prt_riscv_cpu_wb_if.sv
// Bundle of every non-clock signal of the writeback/scoreboard stage.
//   master : the CPU side (ALU, load unit, issue stage); drives the *_IN signals
//   slave  : the writeback stage; drives the *_OUT signals
// Signal names keep the _IN/_OUT direction as seen from the writeback stage.
interface prt_riscv_cpu_wb_if
  import prt_riscv_cpu_pkg::*;
#(
  parameter int unsigned P_IDX = P_IDX_DEF
);

  // ALU result path
  logic             ALU_WR_IN;
  logic [P_IDX-1:0] ALU_IDX_IN;
  logic [31:0]      ALU_DAT_IN;
  // Load issue and response path
  logic             LD_ISSUE_IN;
  logic [P_IDX-1:0] LD_ISSUE_IDX_IN;
  logic             LD_ISSUE_RDY_OUT;
  logic             LD_VLD_IN;
  logic [31:0]      LD_DAT_IN;
  logic             LD_RDY_OUT;
  // Next-instruction hazard query
  logic [P_IDX-1:0] RS1_IDX_IN;
  logic [P_IDX-1:0] RS2_IDX_IN;
  logic [P_IDX-1:0] RD_IDX_IN;
  logic             HAZ_RS1_OUT;
  logic             HAZ_RS2_OUT;
  logic             HAZ_RD_OUT;
  // Register file write port
  logic             RD_WR_OUT;
  logic [P_IDX-1:0] RD_IDX_OUT;
  logic [31:0]      RD_DAT_OUT;
  logic             ERR_OUT;

  modport master (
    output ALU_WR_IN, ALU_IDX_IN, ALU_DAT_IN,
    output LD_ISSUE_IN, LD_ISSUE_IDX_IN, LD_VLD_IN, LD_DAT_IN,
    output RS1_IDX_IN, RS2_IDX_IN, RD_IDX_IN,
    input  LD_ISSUE_RDY_OUT, LD_RDY_OUT,
    input  HAZ_RS1_OUT, HAZ_RS2_OUT, HAZ_RD_OUT,
    input  RD_WR_OUT, RD_IDX_OUT, RD_DAT_OUT, ERR_OUT
  );

  modport slave (
    input  ALU_WR_IN, ALU_IDX_IN, ALU_DAT_IN,
    input  LD_ISSUE_IN, LD_ISSUE_IDX_IN, LD_VLD_IN, LD_DAT_IN,
    input  RS1_IDX_IN, RS2_IDX_IN, RD_IDX_IN,
    output LD_ISSUE_RDY_OUT, LD_RDY_OUT,
    output HAZ_RS1_OUT, HAZ_RS2_OUT, HAZ_RD_OUT,
    output RD_WR_OUT, RD_IDX_OUT, RD_DAT_OUT, ERR_OUT
  );

endinterface

// File: rtl/prt_riscv_cpu_wb_ldq.sv
// In-order queue of destination indices of outstanding loads.
//   clk_i, rst_i            : clock, asynchronous active-high reset (empties queue)
//   push_i, push_idx_i      : enqueue an index (ignored when full)
//   pop_i                   : retire the head (ignored when empty)
//   rdy_o                   : count < P_LDQ, from the registered count only
//   empty_o, head_idx_o     : queue state and oldest index
//   rs1/rs2/rd_idx_i        : indices to compare against every valid entry
//   rs1/rs2/rd_match_o      : any valid entry equals the index (head included)
module prt_riscv_cpu_wb_ldq
  import prt_riscv_cpu_pkg::*;
#(
  parameter int unsigned P_IDX = P_IDX_DEF,
  parameter int unsigned P_LDQ = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [P_IDX-1:0] push_idx_i,
  input  logic             pop_i,
  output logic             rdy_o,
  output logic             empty_o,
  output logic [P_IDX-1:0] head_idx_o,
  input  logic [P_IDX-1:0] rs1_idx_i,
  input  logic [P_IDX-1:0] rs2_idx_i,
  input  logic [P_IDX-1:0] rd_idx_i,
  output logic             rs1_match_o,
  output logic             rs2_match_o,
  output logic             rd_match_o
);

  // A depth of one still gets a 1-bit pointer that never leaves zero.
  localparam int unsigned PtrW = (P_LDQ > 1) ? $clog2(P_LDQ) : 1;
  localparam int unsigned CntW = $clog2(P_LDQ) + 1;

  logic [P_IDX-1:0] idx_q [P_LDQ];
  logic [P_IDX-1:0] idx_d [P_LDQ];
  logic [P_LDQ-1:0] vld_q, vld_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    if (32'(p) == P_LDQ - 1) return '0;
    return p + 1'b1;
  endfunction

  // Readiness comes from the registered count, so a same-cycle pop never frees a slot.
  assign rdy_o      = 32'(cnt_q) < P_LDQ;
  assign empty_o    = cnt_q == '0;
  assign head_idx_o = idx_q[rd_ptr_q];
  assign push_ok    = push_i & rdy_o;
  assign pop_ok     = pop_i & ~empty_o;

  always_comb begin
    idx_d    = idx_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Pop clears first: when both fire the queue is neither full nor empty, so slots differ.
    if (pop_ok) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = ptr_inc(rd_ptr_q);
    end
    if (push_ok) begin
      idx_d[wr_ptr_q] = push_idx_i;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    rs1_match_o = 1'b0;
    rs2_match_o = 1'b0;
    rd_match_o  = 1'b0;
    for (int i = 0; i < P_LDQ; i++) begin
      rs1_match_o = rs1_match_o | (vld_q[i] & (idx_q[i] == rs1_idx_i));
      rs2_match_o = rs2_match_o | (vld_q[i] & (idx_q[i] == rs2_idx_i));
      rd_match_o  = rd_match_o  | (vld_q[i] & (idx_q[i] == rd_idx_i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < P_LDQ; i++) begin
        idx_q[i] <= '0;
      end
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/prt_riscv_cpu_wb.sv
// Writeback/scoreboard stage driving the register-file write port.
//   CLK_IN, RST_IN : clock, asynchronous active-high reset
//   wb_if (slave)  : ALU results, load issue/response, hazard query, RF write port, error
// One registered write per cycle: ALU results take priority, load responses wait.
// Outstanding load destinations sit in an in-order queue used for RAW/WAW hazard flags.
// P_IDX must equal the package P_IDX_DEF since the write register uses wb_port_t.
module prt_riscv_cpu_wb
  import prt_riscv_cpu_pkg::*;
#(
  parameter int unsigned P_REGS = 16,
  parameter int unsigned P_IDX  = P_IDX_DEF,
  parameter int unsigned P_LDQ  = 2
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  prt_riscv_cpu_wb_if.slave wb_if
);

  wb_port_t         wb_q, wb_d;
  logic             err_q, err_d;
  logic             issue_rdy, q_empty, push, ld_rdy;
  logic [P_IDX-1:0] head_idx;
  logic             rs1_match, rs2_match, rd_match;

  // Writable register: not x0, and inside the architectural file.
  function automatic logic idx_live(logic [P_IDX-1:0] idx);
    return idx_nonzero(idx) && (32'(idx) < P_REGS);
  endfunction

  // Hazard: load still owed to idx, or a write to idx sits in the output register.
  function automatic logic haz(logic [P_IDX-1:0] idx, logic q_match);
    return idx_live(idx) && (q_match || (wb_q.wr && (wb_q.idx == idx)));
  endfunction

  assign push   = wb_if.LD_ISSUE_IN & issue_rdy;
  assign ld_rdy = wb_if.LD_VLD_IN & ~wb_if.ALU_WR_IN & ~q_empty;

  prt_riscv_cpu_wb_ldq #(
    .P_IDX(P_IDX),
    .P_LDQ(P_LDQ)
  ) u_ldq (
    .clk_i      (CLK_IN),
    .rst_i      (RST_IN),
    .push_i     (push),
    .push_idx_i (wb_if.LD_ISSUE_IDX_IN),
    .pop_i      (ld_rdy),
    .rdy_o      (issue_rdy),
    .empty_o    (q_empty),
    .head_idx_o (head_idx),
    .rs1_idx_i  (wb_if.RS1_IDX_IN),
    .rs2_idx_i  (wb_if.RS2_IDX_IN),
    .rd_idx_i   (wb_if.RD_IDX_IN),
    .rs1_match_o(rs1_match),
    .rs2_match_o(rs2_match),
    .rd_match_o (rd_match)
  );

  always_comb begin
    wb_d    = wb_q;
    wb_d.wr = 1'b0;
    if (wb_if.ALU_WR_IN) begin
      wb_d.wr  = idx_live(wb_if.ALU_IDX_IN);
      wb_d.idx = wb_if.ALU_IDX_IN;
      wb_d.dat = wb_if.ALU_DAT_IN;
    end else if (ld_rdy) begin
      // Loads to x0 still retire here to keep ordering, but write nothing.
      wb_d.wr  = idx_live(head_idx);
      wb_d.idx = head_idx;
      wb_d.dat = wb_if.LD_DAT_IN;
    end
  end

  always_comb begin
    err_d = err_q;
    if (wb_if.LD_ISSUE_IN && !issue_rdy) err_d = 1'b1;
    if (wb_if.LD_VLD_IN && q_empty)      err_d = 1'b1;
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      err_q <= err_d;
    end
  end

  assign wb_if.LD_ISSUE_RDY_OUT = issue_rdy;
  assign wb_if.LD_RDY_OUT       = ld_rdy;
  assign wb_if.HAZ_RS1_OUT      = haz(wb_if.RS1_IDX_IN, rs1_match);
  assign wb_if.HAZ_RS2_OUT      = haz(wb_if.RS2_IDX_IN, rs2_match);
  assign wb_if.HAZ_RD_OUT       = haz(wb_if.RD_IDX_IN, rd_match);
  assign wb_if.RD_WR_OUT        = wb_q.wr;
  assign wb_if.RD_IDX_OUT       = wb_q.idx;
  assign wb_if.RD_DAT_OUT       = wb_q.dat;
  assign wb_if.ERR_OUT          = err_q;

endmodule

// File: tb/tb_prt_riscv_cpu_wb.sv
// Bench for prt_riscv_cpu_wb: directed scenarios plus random traffic, all outputs
// compared each cycle against a queue-based reference model.
module tb_prt_riscv_cpu_wb;
  import prt_riscv_cpu_pkg::*;

  localparam int LDQ = 2;

  logic clk = 1'b0;
  logic rst;

  prt_riscv_cpu_wb_if #(.P_IDX(4)) bus ();

  prt_riscv_cpu_wb #(
    .P_REGS(16),
    .P_IDX (4),
    .P_LDQ (LDQ)
  ) dut (
    .CLK_IN(clk),
    .RST_IN(rst),
    .wb_if (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          mq[$];
  bit          m_err;
  bit          m_wr;
  int          m_idx;
  logic [31:0] m_dat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit haz_exp(input int idx);
    if (idx == 0) return 1'b0;
    foreach (mq[i]) if (mq[i] == idx) return 1'b1;
    return m_wr && (idx == m_idx);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_err = 1'b0;
    m_wr  = 1'b0;
    m_idx = 0;
    m_dat = '0;
  endtask

  task automatic clear_inputs();
    bus.ALU_WR_IN       = 1'b0;
    bus.ALU_IDX_IN      = '0;
    bus.ALU_DAT_IN      = '0;
    bus.LD_ISSUE_IN     = 1'b0;
    bus.LD_ISSUE_IDX_IN = '0;
    bus.LD_VLD_IN       = 1'b0;
    bus.LD_DAT_IN       = '0;
    bus.RS1_IDX_IN      = '0;
    bus.RS2_IDX_IN      = '0;
    bus.RD_IDX_IN       = '0;
  endtask

  task automatic check_outputs();
    check_eq("issue_rdy", bus.LD_ISSUE_RDY_OUT, 32'(mq.size() < LDQ));
    check_eq("ld_rdy", bus.LD_RDY_OUT,
             32'(bus.LD_VLD_IN && !bus.ALU_WR_IN && mq.size() != 0));
    check_eq("haz_rs1", bus.HAZ_RS1_OUT, 32'(haz_exp(int'(bus.RS1_IDX_IN))));
    check_eq("haz_rs2", bus.HAZ_RS2_OUT, 32'(haz_exp(int'(bus.RS2_IDX_IN))));
    check_eq("haz_rd", bus.HAZ_RD_OUT, 32'(haz_exp(int'(bus.RD_IDX_IN))));
    check_eq("rd_wr", bus.RD_WR_OUT, 32'(m_wr));
    check_eq("rd_idx", bus.RD_IDX_OUT, 32'(m_idx));
    check_eq("rd_dat", bus.RD_DAT_OUT, m_dat);
    check_eq("err", bus.ERR_OUT, 32'(m_err));
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    bit alu, iss, vld, acc, push_ok;
    int head;
    alu     = bus.ALU_WR_IN;
    iss     = bus.LD_ISSUE_IN;
    vld     = bus.LD_VLD_IN;
    acc     = vld && !alu && (mq.size() != 0);
    push_ok = iss && (mq.size() < LDQ);
    if (iss && !push_ok) m_err = 1'b1;
    if (vld && mq.size() == 0) m_err = 1'b1;
    if (alu) begin
      m_idx = int'(bus.ALU_IDX_IN);
      m_wr  = m_idx != 0;
      m_dat = bus.ALU_DAT_IN;
    end else if (acc) begin
      head  = mq[0];
      m_idx = head;
      m_wr  = head != 0;
      m_dat = bus.LD_DAT_IN;
    end else begin
      m_wr = 1'b0;
    end
    if (acc) void'(mq.pop_front());
    if (push_ok) mq.push_back(int'(bus.LD_ISSUE_IDX_IN));
  endtask

  // Called just after a negedge with inputs driven; returns at the next negedge.
  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] pick_idx();
    if (mq.size() > 0 && $urandom_range(0, 1) == 1)
      return 4'(mq[$urandom_range(0, mq.size() - 1)]);
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    do_reset();
    #1;
    check_eq("rst_rd_wr", bus.RD_WR_OUT, 32'd0);
    check_eq("rst_rd_idx", bus.RD_IDX_OUT, 32'd0);
    check_eq("rst_rd_dat", bus.RD_DAT_OUT, 32'd0);
    check_eq("rst_err", bus.ERR_OUT, 32'd0);
    check_eq("rst_issue_rdy", bus.LD_ISSUE_RDY_OUT, 32'd1);

    // ALU write to x5, then RAW hazard while in flight
    bus.ALU_WR_IN = 1'b1; bus.ALU_IDX_IN = 4'd5; bus.ALU_DAT_IN = 32'h1234_5678;
    cycle();
    bus.ALU_WR_IN = 1'b0; bus.RS1_IDX_IN = 4'd5;
    #1;
    check_eq("alu_wr", bus.RD_WR_OUT, 32'd1);
    check_eq("alu_idx", bus.RD_IDX_OUT, 32'd5);
    check_eq("alu_dat", bus.RD_DAT_OUT, 32'h1234_5678);
    check_eq("alu_haz_rs1", bus.HAZ_RS1_OUT, 32'd1);
    cycle();
    #1;
    check_eq("alu_haz_rs1_clr", bus.HAZ_RS1_OUT, 32'd0);
    cycle();

    // Load to x7: hazard while pending and while its write is in flight
    clear_inputs();
    bus.LD_ISSUE_IN = 1'b1; bus.LD_ISSUE_IDX_IN = 4'd7;
    cycle();
    bus.LD_ISSUE_IN = 1'b0; bus.RS2_IDX_IN = 4'd7;
    #1;
    check_eq("ld_haz_rs2", bus.HAZ_RS2_OUT, 32'd1);
    bus.LD_VLD_IN = 1'b1; bus.LD_DAT_IN = 32'hCAFE_F00D;
    #1;
    check_eq("ld_rdy", bus.LD_RDY_OUT, 32'd1);
    cycle();
    bus.LD_VLD_IN = 1'b0;
    #1;
    check_eq("ld_wr", bus.RD_WR_OUT, 32'd1);
    check_eq("ld_idx", bus.RD_IDX_OUT, 32'd7);
    check_eq("ld_dat", bus.RD_DAT_OUT, 32'hCAFE_F00D);
    check_eq("ld_haz_inflight", bus.HAZ_RS2_OUT, 32'd1);
    cycle();
    #1;
    check_eq("ld_haz_clr", bus.HAZ_RS2_OUT, 32'd0);
    cycle();

    // ALU priority over a waiting load response
    clear_inputs();
    bus.LD_ISSUE_IN = 1'b1; bus.LD_ISSUE_IDX_IN = 4'd9;
    cycle();
    bus.LD_ISSUE_IN = 1'b0;
    bus.LD_VLD_IN = 1'b1; bus.LD_DAT_IN = 32'h0BAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      bus.ALU_WR_IN = 1'b1; bus.ALU_IDX_IN = 4'd3; bus.ALU_DAT_IN = $urandom();
      #1;
      check_eq("prio_ld_stall", bus.LD_RDY_OUT, 32'd0);
      cycle();
    end
    bus.ALU_WR_IN = 1'b0;
    #1;
    check_eq("prio_ld_go", bus.LD_RDY_OUT, 32'd1);
    cycle();
    bus.LD_VLD_IN = 1'b0;
    #1;
    check_eq("prio_ld_idx", bus.RD_IDX_OUT, 32'd9);
    cycle();

    // Fill the queue, overflow, then in-order retire
    clear_inputs();
    bus.LD_ISSUE_IN = 1'b1; bus.LD_ISSUE_IDX_IN = 4'd1;
    cycle();
    bus.LD_ISSUE_IDX_IN = 4'd2;
    cycle();
    bus.LD_ISSUE_IDX_IN = 4'd4;
    #1;
    check_eq("full_rdy", bus.LD_ISSUE_RDY_OUT, 32'd0);
    cycle();
    bus.LD_ISSUE_IN = 1'b0;
    #1;
    check_eq("full_err", bus.ERR_OUT, 32'd1);
    bus.LD_VLD_IN = 1'b1; bus.LD_DAT_IN = 32'h1111_1111;
    cycle();
    bus.LD_DAT_IN = 32'h2222_2222;
    #1;
    check_eq("order_first", bus.RD_IDX_OUT, 32'd1);
    cycle();
    bus.LD_VLD_IN = 1'b0;
    #1;
    check_eq("order_second", bus.RD_IDX_OUT, 32'd2);
    cycle();

    // Loads and ALU writes to x0
    clear_inputs();
    bus.LD_ISSUE_IN = 1'b1; bus.LD_ISSUE_IDX_IN = 4'd0;
    cycle();
    bus.LD_ISSUE_IN = 1'b0;
    #1;
    check_eq("x0_haz", bus.HAZ_RS1_OUT, 32'd0);
    bus.LD_VLD_IN = 1'b1;
    cycle();
    bus.LD_VLD_IN = 1'b0;
    #1;
    check_eq("x0_ld_wr", bus.RD_WR_OUT, 32'd0);
    bus.ALU_WR_IN = 1'b1; bus.ALU_IDX_IN = 4'd0; bus.ALU_DAT_IN = 32'hFFFF_FFFF;
    cycle();
    bus.ALU_WR_IN = 1'b0;
    #1;
    check_eq("x0_alu_wr", bus.RD_WR_OUT, 32'd0);
    cycle();

    // Response with empty queue, then asynchronous reset with loads pending
    do_reset();
    bus.LD_VLD_IN = 1'b1;
    #1;
    check_eq("empty_ld_rdy", bus.LD_RDY_OUT, 32'd0);
    cycle();
    bus.LD_VLD_IN = 1'b0;
    #1;
    check_eq("empty_err", bus.ERR_OUT, 32'd1);
    bus.LD_ISSUE_IN = 1'b1; bus.LD_ISSUE_IDX_IN = 4'd10;
    cycle();
    bus.LD_ISSUE_IDX_IN = 4'd11;
    cycle();
    clear_inputs();
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_issue_rdy", bus.LD_ISSUE_RDY_OUT, 32'd1);
    check_eq("async_err", bus.ERR_OUT, 32'd0);
    check_eq("async_rd_wr", bus.RD_WR_OUT, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.LD_VLD_IN = 1'b1;
    cycle();
    bus.LD_VLD_IN = 1'b0;
    #1;
    check_eq("post_rst_resp_err", bus.ERR_OUT, 32'd1);
    cycle();

    // Random traffic in several segments with varying response rates
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        bus.ALU_WR_IN       = ($urandom_range(0, 2) == 0);
        bus.ALU_IDX_IN      = 4'($urandom_range(0, 15));
        bus.ALU_DAT_IN      = $urandom();
        bus.LD_ISSUE_IN     = ($urandom_range(0, 2) == 0);
        bus.LD_ISSUE_IDX_IN = 4'($urandom_range(0, 15));
        bus.LD_VLD_IN       = ($urandom_range(0, 99) < 15 + 15 * seg);
        bus.LD_DAT_IN       = $urandom();
        bus.RS1_IDX_IN      = pick_idx();
        bus.RS2_IDX_IN      = pick_idx();
        bus.RD_IDX_IN       = pick_idx();
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
